// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and alignment helper for the load/store unit
package lsu_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD    = 3'd1,
        ST_RD = 3'd2,
        ST_WR = 3'd3,
        RESP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    function automatic logic is_misaligned(input size_t size, input logic [2:0] offset);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return offset[0];
            SZ_W:    return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and data-memory interfaces of the load/store unit
interface lsu_core_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane extract/extend for loads and lane merge for read-modify-write stores
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]        offset,
    input  size_t             size,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merge_data
);

    logic [5:0]        shamt;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] size_mask;
    logic [DATA_W-1:0] lane_mask;

    always_comb begin
        shamt     = {offset, 3'b000};
        lane      = rdata >> shamt;
        size_mask = '1;
        load_data = lane;
        case (size)
            SZ_B: begin
                size_mask = 64'h0000_0000_0000_00FF;
                load_data = is_unsigned ? {56'b0, lane[7:0]} : {{56{lane[7]}}, lane[7:0]};
            end
            SZ_H: begin
                size_mask = 64'h0000_0000_0000_FFFF;
                load_data = is_unsigned ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            end
            SZ_W: begin
                size_mask = 64'h0000_0000_FFFF_FFFF;
                load_data = is_unsigned ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            end
            default: begin
                size_mask = '1;
                load_data = lane;
            end
        endcase
        // Only the addressed lanes take store data; the rest keep what memory returned.
        lane_mask  = size_mask << shamt;
        merge_data = (rdata & ~lane_mask) | ((wdata << shamt) & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV64 load/store unit: one request at a time, read-modify-write for narrow stores
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_core_if.slave  core,
    lsu_mem_if.master  mem
);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        f3_q;
    logic [2:0]        off_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;

    size_t             req_size;
    logic              req_bad;

    assign req_size = size_t'(core.req_funct3[1:0]);
    assign req_bad  = (core.req_funct3 == 3'b111)
                    | (core.req_is_store & core.req_funct3[2])
                    | is_misaligned(req_size, core.req_addr[2:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Strobes come from the state register alone; rst_n gating kills them in the reset cycle.
    always_comb begin
        state_nxt      = state;
        core.req_ready = 1'b0;
        core.resp_valid = 1'b0;
        mem.mem_read   = 1'b0;
        mem.mem_write  = 1'b0;
        case (state)
            IDLE: begin
                core.req_ready = 1'b1;
                if (core.req_valid) begin
                    if (req_bad)                 state_nxt = RESP;
                    else if (!core.req_is_store) state_nxt = LD;
                    else if (req_size == SZ_D)   state_nxt = ST_WR;
                    else                         state_nxt = ST_RD;
                end
            end
            LD: begin
                mem.mem_read = rst_n;
                state_nxt    = RESP;
            end
            ST_RD: begin
                mem.mem_read = rst_n;
                state_nxt    = ST_WR;
            end
            ST_WR: begin
                mem.mem_write = rst_n;
                state_nxt     = RESP;
            end
            RESP: begin
                core.resp_valid = 1'b1;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core.resp_rdata <= '0;
            core.resp_err   <= 1'b0;
            mem.mem_addr    <= '0;
            mem.mem_wdata   <= '0;
            f3_q            <= '0;
            off_q           <= '0;
            wdata_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core.req_valid) begin
                        f3_q         <= core.req_funct3;
                        off_q        <= core.req_addr[2:0];
                        wdata_q      <= core.req_wdata;
                        mem.mem_addr <= {core.req_addr[ADDR_W-1:3], 3'b000};
                        if (req_bad) begin
                            core.resp_rdata <= '0;
                            core.resp_err   <= 1'b1;
                        end else if (core.req_is_store && req_size == SZ_D) begin
                            mem.mem_wdata <= core.req_wdata;
                        end
                    end
                end
                LD: begin
                    core.resp_rdata <= load_data;
                    core.resp_err   <= 1'b0;
                end
                ST_RD: mem.mem_wdata <= merge_data;
                ST_WR: begin
                    core.resp_rdata <= '0;
                    core.resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    lsu_lane_align u_lane_align (
        .offset      (off_q),
        .size        (size_t'(f3_q[1:0])),
        .is_unsigned (f3_q[2]),
        .rdata       (mem.mem_rdata),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a byte-level memory model
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_core_if core_if ();
    lsu_mem_if  mem_if ();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (core_if),
        .mem   (mem_if)
    );

    logic [63:0] mem_arr [0:31];
    logic [7:0]  ref_b   [0:255];
    int          both_cnt = 0;
    int          wr_total = 0;
    int          n_pass   = 0;
    int          n_checks = 0;

    assign mem_if.mem_rdata = mem_arr[mem_if.mem_addr[7:3]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_err(input logic st, input logic [2:0] f3, input logic [63:0] addr);
        if (f3 == 3'b111 || (st && f3[2])) return 1'b1;
        return (int'(addr[2:0]) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr);
        logic [63:0] v;
        logic [7:0]  idx;
        int          n;
        n = nbytes(f3);
        v = '0;
        for (int i = 0; i < n; i++) begin
            idx = addr[7:0] + 8'(i);
            v = v | (64'(ref_b[idx]) << (8 * i));
        end
        if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wd);
        logic [7:0] idx;
        for (int i = 0; i < nbytes(f3); i++) begin
            idx = addr[7:0] + 8'(i);
            ref_b[idx] = 8'(wd >> (8 * i));
        end
    endtask

    function automatic logic [63:0] ref_word(input logic [4:0] wi);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_b[{wi, 3'(i)}];
        return w;
    endfunction

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, output logic [63:0] got);
        logic        err;
        logic [63:0] exp_rd;
        logic [4:0]  wi;
        int          exp_lat, exp_rds, exp_wrs, lat, rds, wrs;
        err     = ref_err(st, f3, addr);
        exp_rd  = (err || st) ? 64'd0 : ref_load(f3, addr);
        exp_lat = err ? 1 : ((st && f3[1:0] != 2'b11) ? 3 : 2);
        exp_rds = (!err && !(st && f3[1:0] == 2'b11)) ? 1 : 0;
        exp_wrs = (!err && st) ? 1 : 0;
        wi      = addr[7:3];
        if (!err && st) ref_store(f3, addr, wd);
        check("req_ready_idle", 64'(core_if.req_ready), 64'd1);
        core_if.req_valid    = 1'b1;
        core_if.req_is_store = st;
        core_if.req_funct3   = f3;
        core_if.req_addr     = addr;
        core_if.req_wdata    = wd;
        @(posedge clk); #1;
        core_if.req_valid    = 1'b0;
        core_if.req_is_store = 1'($urandom);
        core_if.req_funct3   = 3'($urandom);
        core_if.req_addr     = {$urandom, $urandom};
        core_if.req_wdata    = {$urandom, $urandom};
        lat = 1; rds = 0; wrs = 0;
        while (!core_if.resp_valid && lat < 8) begin
            if (mem_if.mem_read || mem_if.mem_write)
                check("mem_addr", mem_if.mem_addr, {addr[63:3], 3'b000});
            if (mem_if.mem_write) check("mem_wdata", mem_if.mem_wdata, ref_word(wi));
            rds += int'(mem_if.mem_read);
            wrs += int'(mem_if.mem_write);
            @(posedge clk); #1;
            lat++;
        end
        got = core_if.resp_rdata;
        check("resp_valid", 64'(core_if.resp_valid), 64'd1);
        check("latency", 64'(lat), 64'(exp_lat));
        check("resp_rdata", core_if.resp_rdata, exp_rd);
        check("resp_err", 64'(core_if.resp_err), 64'(err));
        check("read_count", 64'(rds), 64'(exp_rds));
        check("write_count", 64'(wrs), 64'(exp_wrs));
        @(posedge clk); #1;
        check("resp_pulse_end", 64'(core_if.resp_valid), 64'd0);
        check("mem_word", mem_arr[wi], ref_word(wi));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mem_if.mem_read && mem_if.mem_write) both_cnt++;
            if (mem_if.mem_write) begin
                wr_total++;
                mem_arr[mem_if.mem_addr[7:3]] = mem_if.mem_wdata;
            end
        end
    end

    initial begin
        logic [63:0] got, w50, wd;
        logic [63:0] b2b_addr [4];
        logic [63:0] b2b_exp  [4];
        logic        st, rdy;
        logic [2:0]  f3;
        logic [63:0] addr;
        int          wr0, acc, pulses, last_acc, cyc;

        for (int i = 0; i < 32; i++) begin
            mem_arr[i] = {$urandom, $urandom};
            for (int j = 0; j < 8; j++) ref_b[i*8+j] = mem_arr[i][8*j +: 8];
        end
        core_if.req_valid    = 1'b0;
        core_if.req_is_store = 1'b0;
        core_if.req_funct3   = 3'b000;
        core_if.req_addr     = '0;
        core_if.req_wdata    = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 64'(core_if.resp_valid), 64'd0);
        check("rst_resp_rdata", core_if.resp_rdata, 64'd0);
        check("rst_resp_err", 64'(core_if.resp_err), 64'd0);
        check("rst_mem_addr", mem_if.mem_addr, 64'd0);
        check("rst_mem_wdata", mem_if.mem_wdata, 64'd0);
        check("rst_mem_read", 64'(mem_if.mem_read), 64'd0);
        check("rst_mem_write", 64'(mem_if.mem_write), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 64'(core_if.req_ready), 64'd1);

        do_req(1'b1, F3_D, 64'h40, 64'h1122334455667788, got);
        do_req(1'b0, F3_D, 64'h40, 64'd0, got);
        check("ld_0x40", got, 64'h1122334455667788);
        do_req(1'b1, F3_B, 64'h43, 64'h00000000000000AB, got);
        check("sb_merge_word", mem_arr[8], 64'h11223344AB667788);

        do_req(1'b1, F3_D, 64'h48, 64'h000000008000FF80, got);
        do_req(1'b0, F3_B, 64'h48, 64'd0, got);
        check("lb_0x48", got, 64'hFFFFFFFFFFFFFF80);
        do_req(1'b0, F3_BU, 64'h48, 64'd0, got);
        check("lbu_0x48", got, 64'h0000000000000080);
        do_req(1'b0, F3_H, 64'h4A, 64'd0, got);
        check("lh_0x4a", got, 64'hFFFFFFFFFFFF8000);
        do_req(1'b0, F3_WU, 64'h48, 64'd0, got);
        check("lwu_0x48", got, 64'h000000008000FF80);

        do_req(1'b0, F3_W, 64'h41, 64'd0, got);
        check("lw_misaligned_rdata", got, 64'd0);
        check("lw_misaligned_err", 64'(core_if.resp_err), 64'd1);
        do_req(1'b1, F3_WU, 64'h40, 64'hDEADBEEFDEADBEEF, got);
        check("store_f3_110_err", 64'(core_if.resp_err), 64'd1);
        check("store_f3_110_mem", mem_arr[8], 64'h11223344AB667788);

        w50 = mem_arr[10];
        wr0 = wr_total;
        core_if.req_valid    = 1'b1;
        core_if.req_is_store = 1'b1;
        core_if.req_funct3   = F3_H;
        core_if.req_addr     = 64'h50;
        core_if.req_wdata    = 64'h000000000000BEEF;
        @(posedge clk); #1;
        core_if.req_valid = 1'b0;
        check("mid_rst_st_rd_read", 64'(mem_if.mem_read), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_read_gated", 64'(mem_if.mem_read), 64'd0);
        check("mid_rst_write_gated", 64'(mem_if.mem_write), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", 64'(core_if.req_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_no_write", 64'(wr_total), 64'(wr0));
        check("mid_rst_mem", mem_arr[10], w50);

        for (int i = 0; i < 4; i++) begin
            b2b_addr[i] = 64'h40 + 64'(8 * i);
            b2b_exp[i]  = ref_load(F3_D, b2b_addr[i]);
        end
        acc = 0; pulses = 0; last_acc = 0; cyc = 0;
        core_if.req_valid    = 1'b1;
        core_if.req_is_store = 1'b0;
        core_if.req_funct3   = F3_D;
        core_if.req_addr     = b2b_addr[0];
        while (pulses < 4 && cyc < 40) begin
            rdy = core_if.req_ready;
            @(posedge clk); #1;
            cyc++;
            if (rdy && acc < 4) begin
                if (acc > 0) check("b2b_accept_gap", 64'(cyc - last_acc), 64'd3);
                last_acc = cyc;
                acc++;
                if (acc < 4) core_if.req_addr = b2b_addr[acc];
                else         core_if.req_valid = 1'b0;
            end
            if (core_if.resp_valid) begin
                check("b2b_rdata", core_if.resp_rdata, b2b_exp[pulses]);
                pulses++;
            end
        end
        check("b2b_accepts", 64'(acc), 64'd4);
        check("b2b_pulses", 64'(pulses), 64'd4);
        @(posedge clk); #1;

        for (int k = 0; k < 60; k++) begin
            st   = 1'($urandom);
            f3   = 3'($urandom_range(0, 7));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) addr[2:0] = addr[2:0] & ~3'(nbytes(f3) - 1);
            wd   = {$urandom, $urandom};
            do_req(st, f3, addr, wd, got);
        end

        check("never_both_strobes", 64'(both_cnt), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: the only block that drives mem_read, mem_write, address and write data toward the 64-bit word-addressed data memory.
- Takes one RV64 load/store request at a time from the SEQ core and handles byte/half/word/double access sizes.
- Sub-doubleword stores use read-modify-write. Loads return zero- or sign-extended data.
- Sits between the execute stage and data memory.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, memory word width; fixed at 64, no other value supported

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_is_store  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 size/sign code
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3; valid with resp_valid
- mem_read  out  1  read strobe to data memory
- mem_write  out  1  write strobe to data memory
- mem_addr  out  64  {req_addr[63:3],3'b000}
- mem_wdata  out  64  full doubleword to write
- mem_rdata  in  64  combinational read data from memory (same cycle as mem_read)

Behaviour:
- Clock is clk. Reset is synchronous, active-low, on rst_n.
- Reset: state=IDLE. All registered outputs are 0: resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata.
  - mem_read and mem_write are gated by rst_n, so they are 0 in any cycle with rst_n=0.
  - req_ready is 1 from the first cycle with rst_n=1.
- Reset mid-operation abandons the access. No write may occur in the reset cycle or after it.
- Request latch: in IDLE, req_valid=1 latches addr, funct3, is_store, wdata. Inputs are ignored outside IDLE.
- funct3 decode:
  - 000 b, 001 h, 010 w, 011 d (signed loads / stores)
  - 100 bu, 101 hu, 110 wu (loads only)
  - 111 is illegal; store with funct3[2]=1 is illegal.
- Alignment: h needs addr[0]=0; w needs addr[1:0]=0; d needs addr[2:0]=0.
- FSM states:
  - IDLE: illegal or misaligned request -> RESP with err=1, no memory strobe. Load -> LD. Store d -> ST_WR. Store b/h/w -> ST_RD.
  - LD: mem_read=1. Extract lane at byte offset addr[2:0], extend per funct3, register into resp_rdata -> RESP.
  - ST_RD: mem_read=1. Capture mem_rdata. Merge the low 8/16/32 bits of wdata into lanes starting at addr[2:0]; other lanes unchanged. Register result to mem_wdata -> ST_WR.
  - ST_WR: mem_write=1, mem_wdata stable (for d: wdata verbatim) -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE. resp_rdata and resp_err are held until the next request completes.
- Latency from accept edge to resp_valid:
  - load: 2 cycles
  - store d: 2 cycles
  - store b/h/w: 3 cycles
  - error: 1 cycle
- Back-to-back throughput: one request per (latency+1) cycles. req_ready falls the cycle after accept.
- mem_read and mem_write are never both 1. Both are decoded from the state register only; there is no combinational path from core inputs.
- mem_addr is held constant from LD/ST_RD through ST_WR.
- Address wrap: none; the upper bits pass through unchanged.

Decomposition:
- lsu_pkg:
  - state enum (IDLE, LD, ST_RD, ST_WR, RESP)
  - funct3 constants F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU
  - size_t enum
- Sub-module lsu_lane_align: combinational lane extract+extend (load) and lane merge (store), from offset, size and sign. This keeps the FSM file small and lets the lane logic be tested on its own.

Test Plan:
- Aligned sd, then ld: sd addr=0x40, wdata=0x1122334455667788 -> mem_write in ST_WR with mem_addr=0x40; ld 0x40 -> resp_rdata=0x1122334455667788, resp_err=0.
- Byte merge: memory[0x40]=0x1122334455667788; sb addr=0x43 wdata=0xAB -> one read, then write of 0x11223344AB667788; exactly 3 cycles accept->resp_valid.
- Sign extension: memory word 0x00000000_8000FF80 at 0x48; lb 0x48 -> 0xFFFFFFFFFFFFFF80; lbu 0x48 -> 0x80; lh 0x4A -> 0xFFFFFFFFFFFF8000; lwu 0x48 -> 0x000000008000FF80.
- Errors: lw 0x41 -> resp_err=1, resp_rdata=0 one cycle after accept, no mem_read or mem_write asserted; store funct3=110 -> resp_err=1, memory unchanged.
- Reset mid-store: sh 0x50 accepted, rst_n=0 during ST_RD -> mem_write never asserted, memory unchanged, req_ready=1 in the first cycle after rst_n returns to 1.
- Back-to-back: req_valid held high with 4 loads -> each accepted only in IDLE, resp_valid pulses exactly 4 times, mem_read and mem_write never both 1.
